// File: rtl/imu_package_sync.sv
// Byte-stream framer: hunts for package start, checks func code and checksum of
// each package, and assembles PACKAGE_NUM clean packages into one parallel frame.
module imu_package_sync #(
  parameter int          PACKAGE_SIZE  = 11,
  parameter int          PACKAGE_NUM   = 4,
  parameter logic [7:0]  START_BYTE    = 8'h55,
  parameter logic [7:0]  FUNC_BASE     = 8'h51,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [7:0]                          byte_i,
  input  logic                                byte_i_vld,
  output logic                                byte_i_rdy,
  output logic [PACKAGE_NUM*PACKAGE_SIZE*8-1:0] frame_o,
  output logic                                frame_o_vld,
  input  logic                                frame_o_rdy,
  output logic [ERR_CNT_WIDTH-1:0]            sum_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0]            seq_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0]            frame_cnt
);
  localparam int FRAME_BYTES = PACKAGE_NUM * PACKAGE_SIZE;
  localparam int FW = FRAME_BYTES * 8;
  localparam int IW = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;
  localparam int CW = $clog2(PACKAGE_SIZE + 1);
  localparam int OW = $clog2(FRAME_BYTES + 1);

  typedef enum logic [1:0] {HUNT, COLLECT, HOLD} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            pkg_q, pkg_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               sum_q, sum_d;
  logic                     rdy_q;
  logic [FW-1:0]            frame_q;
  logic [ERR_CNT_WIDTH-1:0] sum_err_q, seq_err_q, frm_q;
  logic                     wr_en, sum_inc, seq_inc, frm_inc, xfer;
  logic [OW-1:0]            wr_off;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign xfer = byte_i_vld && rdy_q;

  always_comb begin
    state_d = state_q;
    pkg_d   = pkg_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    wr_off  = '0;
    sum_inc = 1'b0;
    seq_inc = 1'b0;
    frm_inc = 1'b0;
    case (state_q)
      HUNT: begin
        if (xfer && byte_i == START_BYTE) begin
          wr_en   = 1'b1;
          sum_d   = START_BYTE;
          cnt_d   = CW'(1);
          pkg_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          wr_en  = 1'b1;
          wr_off = OW'(pkg_q) * OW'(PACKAGE_SIZE) + OW'(cnt_q);
          sum_d  = sum_q + byte_i;
          cnt_d  = cnt_q + 1'b1;
          if ((cnt_q == CW'(0) && byte_i != START_BYTE) ||
              (cnt_q == CW'(1) && byte_i != FUNC_BASE + 8'(pkg_q))) begin
            seq_inc = 1'b1;
            pkg_d   = '0;
            state_d = HUNT;
          end else if (cnt_q == CW'(PACKAGE_SIZE - 1)) begin
            // checksum byte: compare against the sum of the preceding bytes
            if (byte_i != sum_q) begin
              sum_inc = 1'b1;
              pkg_d   = '0;
              state_d = HUNT;
            end else if (pkg_q == IW'(PACKAGE_NUM - 1)) begin
              state_d = HOLD;
            end else begin
              pkg_d = pkg_q + 1'b1;
              cnt_d = '0;
              sum_d = '0;
            end
          end
        end
      end
      HOLD: begin
        if (frame_o_rdy) begin
          frm_inc = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      pkg_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      rdy_q     <= 1'b0;
      sum_err_q <= '0;
      seq_err_q <= '0;
      frm_q     <= '0;
    end else begin
      state_q <= state_d;
      pkg_q   <= pkg_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      // ready is a pure function of the next registered state
      rdy_q   <= (state_d != HOLD);
      if (sum_inc) sum_err_q <= sat_inc(sum_err_q);
      if (seq_inc) seq_err_q <= sat_inc(seq_err_q);
      if (frm_inc) frm_q     <= sat_inc(frm_q);
    end
  end

  // one write-enabled byte slot per frame offset; byte 0 lands at the MSBs
  for (genvar g = 0; g < FRAME_BYTES; g++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             frame_q[FW-1-8*g -: 8] <= '0;
      else if (wr_en && wr_off == OW'(g))     frame_q[FW-1-8*g -: 8] <= byte_i;
    end
  end

  assign byte_i_rdy  = rdy_q;
  assign frame_o     = frame_q;
  assign frame_o_vld = (state_q == HOLD);
  assign sum_err_cnt = sum_err_q;
  assign seq_err_cnt = seq_err_q;
  assign frame_cnt   = frm_q;
endmodule

// File: tb/tb_imu_package_sync.sv
// Directed bench for imu_package_sync: framing, error drop/count, backpressure,
// async reset and counter saturation (second instance with 2-bit counters).
module tb_imu_package_sync;
  localparam int FB = 44;
  localparam int FW = FB * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_i = '0;
  logic          byte_i_vld = 1'b0;
  logic          frame_o_rdy = 1'b1;
  logic          byte_i_rdy, frame_o_vld;
  logic [FW-1:0] frame_o;
  logic [15:0]   sum_err_cnt, seq_err_cnt, frame_cnt;
  logic          s_rdy, s_vld;
  logic [FW-1:0] s_frame;
  logic [1:0]    s_sum, s_seq, s_frm;

  int checks = 0;
  int failures = 0;
  logic [7:0] fb [FB];

  always #5 clk = ~clk;

  imu_package_sync dut (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_i_vld(byte_i_vld),
    .byte_i_rdy(byte_i_rdy), .frame_o(frame_o), .frame_o_vld(frame_o_vld),
    .frame_o_rdy(frame_o_rdy), .sum_err_cnt(sum_err_cnt),
    .seq_err_cnt(seq_err_cnt), .frame_cnt(frame_cnt)
  );

  imu_package_sync #(.ERR_CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_i_vld(byte_i_vld),
    .byte_i_rdy(s_rdy), .frame_o(s_frame), .frame_o_vld(s_vld),
    .frame_o_rdy(frame_o_rdy), .sum_err_cnt(s_sum),
    .seq_err_cnt(s_seq), .frame_cnt(s_frm)
  );

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // fill fb with a clean 4-package frame; data byte j of package k = seed+8k+j
  task automatic build(input logic [7:0] seed);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) begin
      fb[k*11]   = 8'h55;
      fb[k*11+1] = 8'h51 + 8'(k);
      s = 8'h55 + fb[k*11+1];
      for (int j = 2; j < 10; j++) begin
        fb[k*11+j] = seed + 8'(8*k + j);
        s = s + fb[k*11+j];
      end
      fb[k*11+10] = s;
    end
  endtask

  function automatic logic [FW-1:0] packed_fb();
    logic [FW-1:0] v = '0;
    for (int i = 0; i < FB; i++) v = {v[FW-9:0], fb[i]};
    return v;
  endfunction

  // called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b);
    byte_i = b;
    byte_i_vld = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (byte_i_rdy) begin
        @(posedge clk); @(negedge clk);
        return;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("rdy_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(fb[i]);
    byte_i_vld = 1'b0;
  endtask

  task automatic expect_frame(input string tag);
    chk({tag, "_vld"}, FW'(frame_o_vld), FW'(1));
    chk({tag, "_data"}, frame_o, packed_fb());
    @(negedge clk);
    chk({tag, "_vld_drop"}, FW'(frame_o_vld), FW'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_i_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", FW'(byte_i_rdy), FW'(0));
    chk("rst_vld", FW'(frame_o_vld), FW'(0));
    chk("rst_frame", frame_o, FW'(0));
    chk("rst_cnts", FW'({sum_err_cnt, seq_err_cnt, frame_cnt}), FW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy_up", FW'(byte_i_rdy), FW'(1));
  endtask

  initial begin
    // 1: clean frame, latency 1 after last byte
    do_reset();
    build(8'h10);
    send_range(0, FB);
    expect_frame("t1");
    chk("t1_cnts", FW'({sum_err_cnt, seq_err_cnt, frame_cnt}), FW'(48'h0000_0000_0001));

    // 2: garbage prefix dropped silently
    do_reset();
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'h12);
    build(8'h20);
    send_range(0, FB);
    expect_frame("t2");
    chk("t2_seq", FW'(seq_err_cnt), FW'(0));
    chk("t2_frm", FW'(frame_cnt), FW'(1));

    // 3: package 2 checksum corrupted, then a clean frame
    do_reset();
    build(8'h30);
    fb[32] = fb[32] + 8'h01;
    send_range(0, 33);
    chk("t3_novld", FW'(frame_o_vld), FW'(0));
    build(8'h40);
    send_range(0, FB);
    expect_frame("t3");
    chk("t3_sum", FW'(sum_err_cnt), FW'(1));
    chk("t3_seq", FW'(seq_err_cnt), FW'(0));
    chk("t3_frm", FW'(frame_cnt), FW'(1));

    // 4: package 1 func byte wrong, recover on next start byte
    do_reset();
    build(8'h50);
    fb[12] = 8'h53;
    send_range(0, 13);
    build(8'h60);
    send_range(0, FB);
    expect_frame("t4");
    chk("t4_seq", FW'(seq_err_cnt), FW'(1));
    chk("t4_sum", FW'(sum_err_cnt), FW'(0));
    chk("t4_frm", FW'(frame_cnt), FW'(1));

    // 5: downstream backpressure for 20 cycles with input pending
    do_reset();
    frame_o_rdy = 1'b0;
    build(8'h70);
    send_range(0, FB);
    byte_i = 8'h55;
    byte_i_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("t5_vld", FW'(frame_o_vld), FW'(1));
      chk("t5_rdy", FW'(byte_i_rdy), FW'(0));
      chk("t5_hold", frame_o, packed_fb());
      @(negedge clk);
    end
    frame_o_rdy = 1'b1;
    byte_i_vld = 1'b0;
    @(negedge clk);
    chk("t5_vld_drop", FW'(frame_o_vld), FW'(0));
    chk("t5_rdy_up", FW'(byte_i_rdy), FW'(1));
    chk("t5_cnts", FW'({sum_err_cnt, seq_err_cnt, frame_cnt}), FW'(48'h0000_0000_0001));

    // 6: async reset mid-frame, then fresh frame, then counter saturation
    build(8'h80);
    send_range(0, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_frm", FW'(frame_cnt), FW'(0));
    chk("t6_arst_frame", frame_o, FW'(0));
    chk("t6_arst_rdy", FW'(byte_i_rdy), FW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build(8'h90);
    send_range(0, FB);
    expect_frame("t6");
    chk("t6_frm", FW'(frame_cnt), FW'(1));
    build(8'hA0);
    fb[10] = fb[10] ^ 8'hFF;
    for (int n = 0; n < 5; n++) send_range(0, 11);
    @(negedge clk);
    chk("t6_sum16", FW'(sum_err_cnt), FW'(5));
    chk("t6_sum2_sat", FW'(s_sum), FW'(3));
    chk("t6_seq2", FW'(s_seq), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imu_package_sync.md
Name: imu_package_sync

Overview:
- Upstream framing stage between the Bluetooth response FIFO byte stream and the window-assembly stage.
- Hunts for the package start byte and checks each 11-byte package's function code and checksum.
- Assembles PACKAGE_NUM consecutive valid packages into one parallel frame, so the window stage only ever sees aligned, checksum-clean groups.
- Malformed input is dropped and counted; the block resynchronizes on the next start byte.

Parameters:
PACKAGE_SIZE, 11, bytes per package (start, func, 8 data, sum)
PACKAGE_NUM, 4, packages per frame
START_BYTE, 8'h55, package start marker
FUNC_BASE, 8'h51, func code expected for package 0; package k expects FUNC_BASE+k
ERR_CNT_WIDTH, 16, width of the error and frame counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
byte_i  in  8  incoming byte
byte_i_vld  in  1  byte_i valid
byte_i_rdy  out  1  block accepts byte_i
frame_o  out  PACKAGE_NUM*PACKAGE_SIZE*8  assembled frame; first received byte at MSBs
frame_o_vld  out  1  frame_o valid
frame_o_rdy  in  1  downstream accepts frame
sum_err_cnt  out  ERR_CNT_WIDTH  checksum failures, saturating
seq_err_cnt  out  ERR_CNT_WIDTH  start/func sequence failures, saturating
frame_cnt  out  ERR_CNT_WIDTH  frames delivered, saturating

Behaviour:
- Reset (async assert, sync-released by system): state=HUNT, all counters 0, frame_o=0, frame_o_vld=0, byte_i_rdy=0 in the reset cycle, then 1 in HUNT.
- Byte transfer = byte_i_vld && byte_i_rdy at posedge clk. Frame transfer = frame_o_vld && frame_o_rdy.
- byte_i_rdy depends only on registered state: 1 in HUNT and COLLECT, 0 in HOLD. No combinational path from frame_o_rdy.
- Internal state:
  - pkg_idx: 0..PACKAGE_NUM-1
  - byte_cnt: 0..PACKAGE_SIZE-1
  - sum: 8-bit running sum, modulo 256
- HUNT:
  - Accepted byte != START_BYTE: discarded silently, no counter change.
  - Accepted byte == START_BYTE: stored as frame byte 0, sum=START_BYTE, byte_cnt=1, pkg_idx=0, go COLLECT.
- COLLECT, per accepted byte, stored at frame offset pkg_idx*PACKAGE_SIZE+byte_cnt:
  - byte_cnt==0: must equal START_BYTE; else seq_err_cnt++, go HUNT (byte consumed, not rescanned).
  - byte_cnt==1: must equal FUNC_BASE+pkg_idx (8-bit add); else seq_err_cnt++, go HUNT.
  - byte_cnt 2..PACKAGE_SIZE-2: data, added to sum.
  - byte_cnt==PACKAGE_SIZE-1: compared with sum of bytes 0..PACKAGE_SIZE-2.
    - Mismatch: sum_err_cnt++, go HUNT.
    - Match and pkg_idx<PACKAGE_NUM-1: pkg_idx++, byte_cnt=0, sum=0.
    - Match and pkg_idx==PACKAGE_NUM-1: go HOLD, frame_o_vld=1 the next cycle (latency 1 from last byte accepted).
  - Every error path resets pkg_idx=0; partially assembled frame is discarded.
- HOLD:
  - frame_o and frame_o_vld held stable until frame transfer.
  - On transfer: frame_o_vld=0, frame_cnt++, go HUNT; byte_i_rdy rises the following cycle.
  - frame_o_rdy high on the same cycle frame_o_vld rises completes the transfer in that cycle.
- frame_o register holds its last value after transfer; only frame_o_vld qualifies it.
- Counters saturate at all-ones; no wrap.
- A single accepted byte increments at most one counter.
- byte_i_vld low in any state: no state change (stalls are legal mid-package, unlimited length).
- Reset asserted mid-frame or in HOLD: immediate return to reset values; pending frame lost.
- Frame byte order: frame byte 0 at frame_o[MSB -: 8], last checksum byte at frame_o[7:0].

Test Plan:
1. Reset; stream 44 bytes (packages 55 51.., 55 52.., 55 53.., 55 54.. with correct sums), frame_o_rdy=1 -> one cycle frame_o_vld=1 exactly 1 cycle after last byte; frame_o matches bytes in order; frame_cnt=1, error counters 0.
2. Prefix 3 garbage bytes (00 AA 12), then a valid frame -> garbage dropped silently; frame delivered; seq_err_cnt=0.
3. Package 2 checksum byte corrupted (+1), then a full valid frame -> sum_err_cnt=1, no frame for the bad group, second frame delivered, frame_cnt=1.
4. Package 1 func byte 0x53 instead of 0x52, then a valid frame -> seq_err_cnt=1, recovery on next 0x55, frame_cnt=1.
5. frame_o_rdy=0 for 20 cycles after vld with byte_i_vld held high -> byte_i_rdy=0, frame_o stable throughout, no bytes consumed; rdy=1 -> transfer, byte_i_rdy=1 next cycle.
6. Assert rst_n low asynchronously after byte 30 of a frame -> outputs and counters 0 immediately; a fresh valid frame after release is delivered. Also, with ERR_CNT_WIDTH=2, 5 checksum errors -> sum_err_cnt=3 (saturated).
